rpn_sequencer: RTL and testbench

Command initiator for the calculator's 64-entry operand stack. It accepts key tokens over a valid/ready handshake and translates each one into a timed sequence of push/pop/write pulses on the stack, using the stack's top/next/count/error outputs. Integer arithmetic is signed 32-bit, with a multi-cycle divider. It sits between the keypad decoder and the stack; it is the only driver of the stack's command inputs.

---
 rtl/rpn_sequencer_pkg.sv | 41 ++++
 rtl/rpn_sequencer_if.sv | 30 +++
 rtl/rpn_sequencer_divider.sv | 86 ++++++++
 rtl/rpn_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_sequencer_pkg.sv
// calc_pkg: shared constants for the RPN calculator front end.
//   - key token codes delivered by the keypad decoder
//   - sequencer state encoding
//   - error codes reported on err_code
//   - stack count encodings (count is 6 bits; 0 means 64 entries)
package calc_pkg;

  localparam logic [4:0] KEY_DIGIT_MAX   = 5'd9;
  localparam logic [4:0] KEY_ENTER       = 5'd10;
  localparam logic [4:0] KEY_ADD         = 5'd11;
  localparam logic [4:0] KEY_SUB         = 5'd12;
  localparam logic [4:0] KEY_MUL         = 5'd13;
  localparam logic [4:0] KEY_DIV         = 5'd14;
  localparam logic [4:0] KEY_NEG         = 5'd15;
  localparam logic [4:0] KEY_DROP        = 5'd16;
  localparam logic [4:0] KEY_CLEAR_ENTRY = 5'd17;
  localparam logic [4:0] KEY_ALL_CLEAR   = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_DIV   = 3'd2,
    ST_POP   = 3'd3,
    ST_WRITE = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_DIV_ZERO  = 2'd3;

  localparam logic [5:0] STACK_FULL_COUNT = 6'd0;
  localparam logic [5:0] STACK_ONE_COUNT  = 6'd1;
  localparam logic [5:0] STACK_TWO_COUNT  = 6'd2;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Bus bundles around the RPN sequencer.
//   rpn_key_if   : keypad token handshake (key_valid/key_code in, key_ready out)
//                  master = keypad decoder, slave = sequencer
//   rpn_stack_if : operand stack command/status bus
//                  master = sequencer (push/pop/write/value),
//                  slave  = stack (top/next/count/stk_error)
interface rpn_key_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

interface rpn_stack_if #(parameter int WIDTH = 32);
  logic             push;
  logic             pop;
  logic             write;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [5:0]       count;
  logic             stk_error;

  modport master (output push, output pop, output write, output value,
                  input top, input next, input count, input stk_error);
  modport slave  (input push, input pop, input write, input value,
                  output top, output next, output count, output stk_error);
endinterface

// File: rtl/rpn_sequencer_divider.sv
// serial_divider: signed restoring divider with fixed latency.
//   clock, reset_n : system clock, asynchronous active-low reset
//   start          : load operands (one-cycle pulse)
//   dividend       : signed numerator
//   divisor        : signed denominator (caller guarantees non-zero)
//   done           : high in the last of DIV_CYCLES iteration cycles
//   quotient       : truncated-toward-zero quotient, valid while done=1
// Works on magnitudes; |INT_MIN| fits unsigned, so INT_MIN / -1 wraps to INT_MIN.
module serial_divider #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

  logic             running;
  logic [CNT_W-1:0] iter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    mag_a = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    mag_b = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  end

  // One restoring step. The quotient register shifts the dividend out at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dsr};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // The final step is presented combinationally so the caller can capture the
  // result at the end of the last iteration cycle.
  assign done     = running && (iter == LAST);
  assign quotient = $signed(neg ? (~quo_nx + WIDTH'(1)) : quo_nx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      iter    <= '0;
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
      neg     <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= '0;
      rem     <= '0;
      quo     <= mag_a;
      dsr     <= mag_b;
      neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
    end else if (running) begin
      rem  <= rem_nx;
      quo  <= quo_nx;
      iter <= iter + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: turns keypad tokens into push/pop/write sequences on the
// 64-entry operand stack.
//   clock, reset_n : system clock, asynchronous active-low reset
//   key            : token handshake (slave side)
//   stk            : stack command/status bus (master side)
//   busy           : sequencer is not idle
//   err, err_code  : sticky error flag and last error code
module rpn_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  rpn_key_if.slave    key,
  rpn_stack_if.master stk,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  state_t           state;
  state_t           state_nx;
  logic [4:0]       code;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;

  logic             push_c;
  logic             pop_c;
  logic             err_set;
  logic [1:0]       err_set_code;
  logic             err_clr;

  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;

  logic             is_one;
  logic             is_full;
  logic             is_two;

  assign is_one  = (stk.count == STACK_ONE_COUNT);
  assign is_two  = (stk.count == STACK_TWO_COUNT);
  assign is_full = (stk.count == STACK_FULL_COUNT);

  serial_divider #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (stk.next),
    .divisor  (stk.top),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_nx     = state;
    res_nx       = res;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    err_set      = 1'b0;
    err_set_code = ERR_NONE;
    err_clr      = 1'b0;
    div_start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key.key_valid) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        state_nx = ST_IDLE;
        if (is_digit(code)) begin
          res_nx   = stk.top * WIDTH'(10) + WIDTH'(code);
          state_nx = ST_WRITE;
        end else begin
          case (code)
            KEY_ENTER: begin
              if (is_full) begin
                err_set      = 1'b1;
                err_set_code = ERR_OVERFLOW;
              end else begin
                push_c = 1'b1;
              end
            end
            KEY_ADD, KEY_SUB, KEY_MUL: begin
              if (is_one) begin
                err_set      = 1'b1;
                err_set_code = ERR_UNDERFLOW;
              end else begin
                if (code == KEY_ADD)      res_nx = stk.next + stk.top;
                else if (code == KEY_SUB) res_nx = stk.next - stk.top;
                else                      res_nx = stk.next * stk.top;
                state_nx = ST_POP;
              end
            end
            KEY_DIV: begin
              if (is_one) begin
                err_set      = 1'b1;
                err_set_code = ERR_UNDERFLOW;
              end else if (stk.top == '0) begin
                err_set      = 1'b1;
                err_set_code = ERR_DIV_ZERO;
              end else begin
                div_start = 1'b1;
                state_nx  = ST_DIV;
              end
            end
            KEY_NEG: begin
              res_nx   = ~stk.top + WIDTH'(1);
              state_nx = ST_WRITE;
            end
            KEY_DROP: begin
              if (is_one) begin
                res_nx   = '0;
                state_nx = ST_WRITE;
              end else begin
                pop_c = 1'b1;
              end
            end
            KEY_CLEAR_ENTRY: begin
              res_nx   = '0;
              state_nx = ST_WRITE;
            end
            KEY_ALL_CLEAR: begin
              err_clr  = 1'b1;
              res_nx   = '0;
              state_nx = is_one ? ST_WRITE : ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
      ST_DIV: begin
        if (div_done) begin
          res_nx   = div_q;
          state_nx = ST_POP;
        end
      end
      ST_POP: begin
        pop_c    = 1'b1;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        state_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        // The pop that leaves one entry goes straight to WRITE, so the final
        // write follows the last pop with no gap cycle.
        if (is_one) begin
          state_nx = ST_WRITE;
        end else begin
          pop_c = 1'b1;
          if (is_two) state_nx = ST_WRITE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      code  <= '0;
      res   <= '0;
    end else begin
      state <= state_nx;
      res   <= res_nx;
      if (state == ST_IDLE && key.key_valid) code <= key.key_code;
    end
  end

  // A stack pointer fault outranks everything else on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_set_code;
      end
      if (stk.stk_error) begin
        err      <= 1'b1;
        err_code <= ERR_OVERFLOW;
      end
    end
  end

  assign key.key_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign stk.push      = push_c;
  assign stk.pop       = pop_c;
  assign stk.write     = (state == ST_WRITE);
  assign stk.value     = res;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: behavioural 64-entry stack (push inserts 0),
// directed key sequences, and a scoreboard of expected stack commands
// (kind, value, cycle) consumed by an independent monitor.
module tb_rpn_sequencer;
  import calc_pkg::*;

  localparam int W       = 32;
  localparam int C_PUSH  = 1;
  localparam int C_POP   = 2;
  localparam int C_WRITE = 3;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic       stk_err = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rpn_key_if ki ();
  rpn_stack_if #(.WIDTH(W)) si ();

  rpn_sequencer #(.WIDTH(W), .DIV_CYCLES(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .key      (ki),
    .stk      (si),
    .busy     (busy),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural stack: entry 0 is top; mn entries (1..64); count 64 reads as 0.
  logic [W-1:0] mstk [0:63] = '{default: '0};
  int mn = 1;

  always @(posedge clock) begin
    if (si.push) begin
      for (int i = 63; i > 0; i--) mstk[i] <= mstk[i-1];
      mstk[0] <= '0;
      if (mn < 64) mn <= mn + 1;
    end else if (si.pop) begin
      for (int i = 0; i < 63; i++) mstk[i] <= mstk[i+1];
      mstk[63] <= '0;
      if (mn > 1) mn <= mn - 1;
    end else if (si.write) begin
      mstk[0] <= si.value;
    end
  end

  assign si.top       = mstk[0];
  assign si.next      = mstk[1];
  assign si.count     = mn[5:0];
  assign si.stk_error = stk_err;

  typedef struct {
    int           kind;
    logic [W-1:0] val;
    int           at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input int kind, input logic [W-1:0] val, input int at);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: cycle label t+k means the k-th clock period after transfer edge t.
  int   m_kind;
  exp_t m_e;
  always @(negedge clock) begin
    if (reset_n && (si.push || si.pop || si.write)) begin
      m_kind = si.push ? C_PUSH : (si.pop ? C_POP : C_WRITE);
      chk("cmd_onehot", int'(si.push) + int'(si.pop) + int'(si.write), 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd: got kind %0d value %0d at cycle %0d, want no command", m_kind, si.value, cyc + 1);
      end else begin
        m_e = sb.pop_front();
        chk("cmd_kind", m_kind, m_e.kind);
        chk("cmd_cycle", cyc + 1, m_e.at);
        if (m_kind == C_WRITE) chk("write_value", si.value, m_e.val);
      end
    end
  end

  task automatic send(input logic [4:0] c, output int t);
    @(negedge clock);
    ki.key_valid = 1'b1;
    ki.key_code  = c;
    @(posedge clock);
    #1;
    ki.key_valid = 1'b0;
    t = cyc;
  endtask

  task automatic wait_ready(input int t, input int lat);
    int n = 0;
    @(negedge clock);
    while (!ki.key_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!ki.key_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: key_ready still 0 after %0d cycles, want ready at t+%0d", n, lat);
    end else begin
      chk("ready_latency", cyc + 1 - t, lat);
    end
  endtask

  task automatic k_write(input logic [4:0] c, input logic [W-1:0] v);
    int t;
    send(c, t);
    expect_cmd(C_WRITE, v, t + 2);
    wait_ready(t, 3);
  endtask

  task automatic k_push();
    int t;
    send(KEY_ENTER, t);
    expect_cmd(C_PUSH, '0, t + 1);
    wait_ready(t, 2);
  endtask

  task automatic k_binop(input logic [4:0] c, input logic [W-1:0] v);
    int t;
    send(c, t);
    expect_cmd(C_POP, '0, t + 2);
    expect_cmd(C_WRITE, v, t + 3);
    wait_ready(t, 4);
  endtask

  task automatic k_none(input logic [4:0] c);
    int t;
    send(c, t);
    wait_ready(t, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    ki.key_valid = 1'b0;
    ki.key_code  = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    chk("rst_key_ready", ki.key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmds", {si.push, si.pop, si.write}, 0);
    chk("rst_value", si.value, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);

    // 1 2 ENTER 3 ADD -> 15
    k_write(5'd1, 32'd1);
    k_write(5'd2, 32'd12);
    k_push();
    k_write(5'd3, 32'd3);
    k_binop(KEY_ADD, 32'd15);
    chk("add_top", si.top, 15);
    chk("add_count", si.count, 1);

    // 7 ENTER 2 NEG DIV -> -3 with exact divider timing
    k_write(KEY_CLEAR_ENTRY, 32'd0);
    k_write(5'd7, 32'd7);
    k_push();
    k_write(5'd2, 32'd2);
    k_write(KEY_NEG, 32'hFFFF_FFFE);
    send(KEY_DIV, t);
    expect_cmd(C_POP, '0, t + 34);
    expect_cmd(C_WRITE, 32'hFFFF_FFFD, t + 35);
    wait_ready(t, 36);
    chk("div_top", si.top, 32'hFFFF_FFFD);
    chk("div_count", si.count, 1);

    // 5 ENTER 0 DIV -> divide by zero, stack untouched
    k_write(KEY_CLEAR_ENTRY, 32'd0);
    k_write(5'd5, 32'd5);
    k_push();
    k_write(5'd0, 32'd0);
    k_none(KEY_DIV);
    chk("dz_err", err, 1);
    chk("dz_err_code", err_code, ERR_DIV_ZERO);
    chk("dz_top", si.top, 0);
    chk("dz_next", si.next, 5);
    chk("dz_count", si.count, 2);

    // ALL_CLEAR from two entries, then underflow on ADD
    send(KEY_ALL_CLEAR, t);
    expect_cmd(C_POP, '0, t + 2);
    expect_cmd(C_WRITE, '0, t + 3);
    wait_ready(t, 4);
    chk("ac2_err", err, 0);
    chk("ac2_err_code", err_code, ERR_NONE);
    k_none(KEY_ADD);
    chk("uf_err_code", err_code, ERR_UNDERFLOW);
    chk("uf_count", si.count, 1);

    // ALL_CLEAR with a single entry
    send(KEY_ALL_CLEAR, t);
    expect_cmd(C_WRITE, '0, t + 2);
    wait_ready(t, 3);
    chk("ac1_err", err, 0);

    // Fill to 64 entries, then one ENTER too many
    for (int i = 0; i < 63; i++) k_push();
    chk("full_count", si.count, 0);
    k_none(KEY_ENTER);
    chk("of_err", err, 1);
    chk("of_err_code", err_code, ERR_OVERFLOW);
    chk("of_count", si.count, 0);

    // ALL_CLEAR from a full stack: 63 pops then a write
    send(KEY_ALL_CLEAR, t);
    for (int i = 2; i <= 64; i++) expect_cmd(C_POP, '0, t + i);
    expect_cmd(C_WRITE, '0, t + 65);
    wait_ready(t, 66);
    chk("ac64_count", si.count, 1);
    chk("ac64_err", err, 0);

    // Four entries with an error pending, then ALL_CLEAR
    k_push();
    k_push();
    k_push();
    k_none(KEY_DIV);
    chk("dz4_err_code", err_code, ERR_DIV_ZERO);
    k_write(5'd9, 32'd9);
    send(KEY_ALL_CLEAR, t);
    expect_cmd(C_POP, '0, t + 2);
    expect_cmd(C_POP, '0, t + 3);
    expect_cmd(C_POP, '0, t + 4);
    expect_cmd(C_WRITE, '0, t + 5);
    wait_ready(t, 6);
    chk("ac4_err", err, 0);
    chk("ac4_top", si.top, 0);
    chk("ac4_count", si.count, 1);

    // MUL, SUB, DROP both ways, ignored code
    k_write(5'd6, 32'd6);
    k_push();
    k_write(5'd7, 32'd7);
    k_binop(KEY_MUL, 32'd42);
    k_push();
    k_write(5'd5, 32'd5);
    k_binop(KEY_SUB, 32'd37);
    k_write(KEY_DROP, 32'd0);
    k_write(5'd3, 32'd3);
    k_push();
    send(KEY_DROP, t);
    expect_cmd(C_POP, '0, t + 1);
    wait_ready(t, 2);
    k_none(5'd25);
    chk("misc_top", si.top, 3);
    chk("misc_count", si.count, 1);
    chk("misc_err", err, 0);

    // Stack pointer fault reported by the stack
    @(negedge clock);
    stk_err = 1'b1;
    @(negedge clock);
    stk_err = 1'b0;
    #1;
    chk("stk_err_flag", err, 1);
    chk("stk_err_code", err_code, ERR_OVERFLOW);
    send(KEY_ALL_CLEAR, t);
    expect_cmd(C_WRITE, '0, t + 2);
    wait_ready(t, 3);
    chk("stk_err_cleared", err, 0);

    // Reset in the middle of a division abandons the sequence
    k_write(5'd8, 32'd8);
    k_push();
    k_write(5'd2, 32'd2);
    send(KEY_DIV, t);
    repeat (9) @(posedge clock);
    #2;
    chk("mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ki.key_ready, 1);
    chk("mid_rst_cmds", {si.push, si.pop, si.write}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (45) @(negedge clock);
    chk("post_rst_count", si.count, 2);
    chk("post_rst_top", si.top, 2);
    chk("post_rst_err", err, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
